instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the CPU decode/execute stage. Owns the program counter and issues
//  byte reads to the memory port, one outstanding request at a time. Buffers returned
//  instruction bytes, each tagged with its PC, in a prefetch FIFO with a valid/ready handshake.
//  Executed jumps (JMP/JMPZ/JMPS/JMPZS) redirect the PC and flush stale bytes.
// PARAMETERS
//  ADDR_W     16       PC / memory address width
//  DATA_W     8        instruction byte width
//  FIFO_DEPTH 4        prefetch entries (power of 2, >=2)
//  RESET_VEC  16'hFFFC PC value after reset
// PORTS
//  clk          in  1       clock, rising edge
//  reset        in  1       asynchronous, active-low
//  mem_rd_req   out 1       read request
//  mem_rd_addr  out ADDR_W  read address
//  mem_rd_ack   in  1       request accepted this cycle (sampled with req)
//  mem_rd_valid in  1       read data returned, >=1 cycle after ack
//  mem_rd_data  in  DATA_W  read data
//  redir_valid  in  1       PC redirect (taken jump) from execute
//  redir_pc     in  ADDR_W  redirect target
//  ins_valid    out 1       FIFO head valid
//  ins_data     out DATA_W  FIFO head byte
//  ins_pc       out ADDR_W  address of ins_data
//  ins_ready    in  1       decode consumes head when ins_valid&ins_ready
//  fifo_count   out $clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; fetch_pc=RESET_VEC; FIFO empty; mem_rd_req=0,
//   mem_rd_addr=RESET_VEC, ins_valid=0, ins_data=0, ins_pc=0, fifo_count=0.
//  mem_rd_addr always equals fetch_pc. Memory samples addr only on a req&ack cycle;
//   before ack, req may drop and addr may change.
//  Credit: a request may be issued only while fifo_count + outstanding < FIFO_DEPTH.
//  FSM (all registered):
//   IDLE -> REQ when credit available; req=1.
//   REQ : req=1. ack -> WAIT, fetch_pc++ (wraps FFFF->0000), latch req_pc=fetch_pc.
//   WAIT: req=0. mem_rd_valid -> push {data,req_pc}; go REQ if credit remains, else IDLE.
//   DROP: req=0. mem_rd_valid -> discard data; go REQ.
//  Redirect (priority over every other event in the same cycle):
//   FIFO flushed; popped head, if any, is void; fetch_pc <= redir_pc.
//   IDLE/REQ without ack -> REQ (new addr next cycle).
//   REQ with ack, or WAIT without mem_rd_valid -> DROP.
//   WAIT with mem_rd_valid -> data discarded -> REQ.
//   DROP -> stays DROP; the pending response is still discarded.
//  Latency: response at cycle t -> ins_valid at t+1 (no bypass).
//   Redirect at t -> mem_rd_req with addr=redir_pc at t+1 unless DROP.
//  FIFO: push and pop in the same cycle allowed; count unchanged. Push when full is
//   impossible by credit rule. Pop when empty is ignored.
//  mem_rd_valid in IDLE/REQ is a protocol violation; it is ignored, with no state change.
//  Head outputs hold stable while ins_valid=1 and ins_ready=0.
// TESTING
//  1 Reset release, 1-cycle memory -> addr FFFC,FFFD,FFFE,FFFF,0000; ins_pc follows; PC wraps.
//  2 ins_ready=0, 1-cycle memory -> fifo_count stops at 4, req stays 0. One pop -> one new request.
//  3 redir_pc=0x0200 while WAIT, data arrives 3 cycles later -> data dropped; next req addr 0200;
//    first ins_pc=0200.
//  4 redirect same cycle as mem_rd_valid and ins_ready -> FIFO empty next cycle;
//    no stale byte reaches ins_data.
//  5 reset asserted mid-WAIT -> all outputs at reset values immediately; a late
//    mem_rd_valid after release is ignored.
//  6 ack delayed 5 cycles -> req and addr held stable; exactly one push per ack.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory read port, redirect input and decode-side prefetch handshake of the fetch unit
interface instr_fetch_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic [CNT_W-1:0]  fifo_count;
    modport master (
        output mem_rd_req, mem_rd_addr, ins_valid, ins_data, ins_pc, fifo_count,
        input  mem_rd_ack, mem_rd_valid, mem_rd_data, redir_valid, redir_pc, ins_ready
    );
    modport slave (
        input  mem_rd_req, mem_rd_addr, ins_valid, ins_data, ins_pc, fifo_count,
        output mem_rd_ack, mem_rd_valid, mem_rd_data, redir_valid, redir_pc, ins_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues one byte read at a time and buffers PC-tagged bytes
// in a prefetch FIFO; taken jumps redirect the PC and flush stale bytes.
module instr_fetch_unit #(
    parameter int              ADDR_W     = 16,
    parameter int              DATA_W     = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = 16'hFFFC
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
    state_t            r_state, w_nxt;
    logic              r_req;
    logic [ADDR_W-1:0] r_fetch_pc, r_req_pc;
    logic [DATA_W-1:0] r_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_pc [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              w_ack, w_push, w_pop, w_credit, w_drop;
    assign w_ack       = r_state == REQ && bus.mem_rd_ack;
    assign w_push      = r_state == WAIT && bus.mem_rd_valid;
    assign w_pop       = bus.ins_valid && bus.ins_ready;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_credit    = w_count_nxt < CNT_W'(FIFO_DEPTH);
    // A redirect must still swallow a response that has been accepted but not yet returned
    assign w_drop      = w_ack || ((r_state == WAIT || r_state == DROP) && !bus.mem_rd_valid);
    always_comb begin
        w_nxt = bus.redir_valid ? (w_drop ? DROP : REQ) :
                r_state == IDLE ? (w_credit ? REQ : IDLE) :
                r_state == REQ  ? (bus.mem_rd_ack ? WAIT : REQ) :
                r_state == WAIT ? (bus.mem_rd_valid ? (w_credit ? REQ : IDLE) : WAIT) :
                                  (bus.mem_rd_valid ? REQ : DROP);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_fetch_pc <= RESET_VEC;
            r_req_pc   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_nxt;
            r_req      <= w_nxt == REQ;
            r_fetch_pc <= bus.redir_valid ? bus.redir_pc : w_ack ? r_fetch_pc + 1'b1 : r_fetch_pc;
            r_req_pc   <= w_ack ? r_fetch_pc : r_req_pc;
            r_wr_ptr   <= bus.redir_valid ? '0 : w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr   <= bus.redir_valid ? '0 : w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count    <= bus.redir_valid ? '0 : w_count_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= bus.mem_rd_data;
            r_pc[r_wr_ptr]   <= r_req_pc;
        end
    end
    assign bus.mem_rd_req  = r_req;
    assign bus.mem_rd_addr = r_fetch_pc;
    assign bus.fifo_count  = r_count;
    assign bus.ins_valid   = r_count != '0;
    // Head is forced to zero while empty so flushed bytes never appear on the outputs
    assign bus.ins_data    = bus.ins_valid ? r_data[r_rd_ptr] : '0;
    assign bus.ins_pc      = bus.ins_valid ? r_pc[r_rd_ptr] : '0;
endmodule
